multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameters SHALL be: OPCODE_W, default 6, opcode field width; ALUOP_W, default 3, ALU-op bus width (minimum 3); STATE_W, default 4, width of the state debug output.
REQ-002 Ports SHALL be: clk in 1 system clock; reset in 1 asynchronous active-low reset; opcode in OPCODE_W instruction opcode, valid from DECODE onward; zero in 1 ALU zero flag; mem_ready in 1 memory handshake, data accepted or returned this cycle.
REQ-003 Ports SHALL continue: pc_write out 1; pc_write_cond out 1; iord out 1; mem_read out 1; mem_write out 1; ir_write out 1; reg_dst out 1; reg_write out 1; mem_to_reg out 1; jumpandlink out 1; alu_src_a out 1; alu_src_b out 2; alu_op out ALUOP_W; pc_source out 2; instr_done out 1; illegal_op out 1; state out STATE_W.
REQ-004 The block SHALL have one clock, clk; reset SHALL be asynchronous and active-low.

Function
REQ-005 The state register SHALL be the only storage; all outputs SHALL decode from state (Moore), except where the mem_ready and zero qualifiers below apply.
REQ-006 State encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, IMMEX=10, IMMWB=11, JAL=12, ILLEGAL=13.
REQ-007 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=000 (add); ir_write, pc_write=mem_ready; hold while mem_ready=0, go to DECODE when mem_ready=1.
REQ-008 DECODE: alu_src_a=0, alu_src_b=11, alu_op=000 (branch target); next state by opcode: 0->EXEC, 35/43->MEMADR, 4->BRANCH, 2->JUMP, 8/12/13->IMMEX, 3->JAL, any other->ILLEGAL.
REQ-009 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=000; go to MEMRD if opcode=35, else to MEMWR.
REQ-010 MEMRD: mem_read=1, iord=1; hold until mem_ready=1, then go to MEMWB; MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; then FETCH.
REQ-011 MEMWR: mem_write=1, iord=1; hold until mem_ready=1, then go to FETCH.
REQ-012 EXEC: alu_src_a=1, alu_src_b=00, alu_op=010; RWB: reg_write=1, reg_dst=1, mem_to_reg=0; then FETCH.
REQ-013 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001 (sub), pc_write_cond=1, pc_source=01; the PC SHALL load only when zero=1; then FETCH.
REQ-014 JUMP: pc_write=1, pc_source=10; then FETCH.
REQ-015 IMMEX: alu_src_a=1, alu_src_b=10; alu_op SHALL be 000 for opcode 8, 011 (and) for 12, 100 (or) for 13. IMMWB: reg_write=1, reg_dst=0, mem_to_reg=0; then FETCH.
REQ-016 JAL: reg_write=1, jumpandlink=1, pc_write=1, pc_source=10; then FETCH.
REQ-017 ILLEGAL: illegal_op=1 for exactly one cycle, no register or memory write; then FETCH.
REQ-018 instr_done SHALL pulse 1 in the last cycle of each instruction: MEMWB, MEMWR when mem_ready=1, RWB, BRANCH, JUMP, IMMWB, JAL, ILLEGAL.
REQ-019 Every output not listed for a state SHALL be 0; no output SHALL ever be X.
REQ-020 With mem_ready held at 1, latencies in cycles SHALL be: R-type 4, LW 5, SW 4, BEQ 3, J 3, JAL 3, immediate 4.

Reset
REQ-021 reset=0 SHALL force state to FETCH immediately, including mid-instruction or mid-wait, and SHALL force every output to 0 while asserted.
REQ-022 FETCH outputs SHALL appear in the first cycle after reset deasserts; no partial write SHALL complete after reset is asserted.

Configuration
REQ-023 Macro MULTICYCLE_CONTROL_JAL_EN: when defined, the JAL state and opcode 3 decode SHALL exist per REQ-016.
REQ-024 When MULTICYCLE_CONTROL_JAL_EN is undefined, opcode 3 SHALL go to ILLEGAL, jumpandlink SHALL be tied to 0, and encoding 12 SHALL be unused.

Verification
REQ-025 R-type: opcode=0, mem_ready=1 -> states 0,1,6,7; reg_write=1 and reg_dst=1 in cycle 4; instr_done=1 in cycle 4.
REQ-026 LW with memory waits: opcode=35, mem_ready=0 for 2 cycles in MEMRD -> state stays 3 for 3 cycles with mem_read=1 and iord=1, then 4 with mem_to_reg=1.
REQ-027 BEQ: opcode=4, zero=0 -> pc_write_cond=1, pc_source=01, alu_op=001, and the PC does not load; with zero=1 the PC loads; both cases return to FETCH after 3 cycles.
REQ-028 Illegal opcode: opcode=63 -> DECODE then ILLEGAL (13) with illegal_op=1 for 1 cycle, no writes, then FETCH; opcode=3 with macro undefined -> same.
REQ-029 Reset mid-instruction: reset=0 in MEMWR while mem_ready=0 -> asynchronously all outputs 0 and state 0; after release, FETCH with mem_read=1.
REQ-030 ORI/ANDI: opcode=13 -> alu_op=100 in IMMEX, then IMMWB with reg_write=1 and reg_dst=0; opcode=12 -> alu_op=011.

Source files
------------

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Brief    : Moore-style main controller for a multicycle MIPS-like datapath.
//            Optional JAL support is enabled by MULTICYCLE_CONTROL_JAL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 3,
    parameter int STATE_W  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic                jumpandlink,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic [1:0]          pc_source,
    output logic                instr_done,
    output logic                illegal_op,
    output logic [STATE_W-1:0]  state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXEC    = 4'd6,
        RWB     = 4'd7,
        BRANCH  = 4'd8,
        JUMP    = 4'd9,
        IMMEX   = 4'd10,
        IMMWB   = 4'd11,
`ifdef MULTICYCLE_CONTROL_JAL_EN
        JAL     = 4'd12,
`endif
        ILLEGAL = 4'd13
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_JAL   = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(8);
    localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'(12);
    localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'(13);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(35);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(43);

    localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(3'b000);
    localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(3'b001);
    localparam logic [ALUOP_W-1:0] ALU_FUNC = ALUOP_W'(3'b010);
    localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(3'b011);
    localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(3'b100);

    state_t state_q, state_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (mem_ready) state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_RTYPE:                  state_d = EXEC;
                    OP_LW, OP_SW:              state_d = MEMADR;
                    OP_BEQ:                    state_d = BRANCH;
                    OP_J:                      state_d = JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI:  state_d = IMMEX;
`ifdef MULTICYCLE_CONTROL_JAL_EN
                    OP_JAL:                    state_d = JAL;
`endif
                    default:                   state_d = ILLEGAL;
                endcase
            end
            MEMADR:  state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   if (mem_ready) state_d = MEMWB;
            MEMWR:   if (mem_ready) state_d = FETCH;
            EXEC:    state_d = RWB;
            IMMEX:   state_d = IMMWB;
            default: state_d = FETCH;
        endcase
    end

    // Outputs decode from the state register; reset gates them low asynchronously.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        jumpandlink   = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = ALU_ADD;
        pc_source     = 2'b00;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        state         = '0;
        if (reset) begin
            state = STATE_W'(state_q);
            case (state_q)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                DECODE: alu_src_b = 2'b11;
                MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                MEMRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                end
                MEMWR: begin
                    mem_write  = 1'b1;
                    iord       = 1'b1;
                    instr_done = mem_ready;
                end
                EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_FUNC;
                end
                RWB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                end
                BRANCH: begin
                    // The PC load itself is qualified by zero; pc_write_cond flags the branch.
                    alu_src_a     = 1'b1;
                    alu_op        = ALU_SUB;
                    pc_write_cond = 1'b1;
                    pc_write      = zero;
                    pc_source     = 2'b01;
                    instr_done    = 1'b1;
                end
                JUMP: begin
                    pc_write   = 1'b1;
                    pc_source  = 2'b10;
                    instr_done = 1'b1;
                end
                IMMEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    if (opcode == OP_ANDI) begin
                        alu_op = ALU_AND;
                    end else if (opcode == OP_ORI) begin
                        alu_op = ALU_OR;
                    end
                end
                IMMWB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
`ifdef MULTICYCLE_CONTROL_JAL_EN
                JAL: begin
                    reg_write   = 1'b1;
                    jumpandlink = 1'b1;
                    pc_write    = 1'b1;
                    pc_source   = 2'b10;
                    instr_done  = 1'b1;
                end
`endif
                ILLEGAL: begin
                    illegal_op = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
